// File: rtl/pause_sequencer.sv
// Sequenced pause controller: merges pause requests, strobes start-pause, collects acks,
// publishes the formal paused state, with ack timeout and a guaranteed quiet resume phase.
module pause_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned QUIET_CYC   = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_pinPause,
    input  logic       i_jtagPause,
    input  logic       i_mapPause,
    input  logic       i_isBooted,
    input  logic       i_coreNowPaused,
    input  logic       i_mapNowPaused,
    input  logic       i_clrTimeout,
    output logic       o_startPause,
    output logic       o_isPaused,
    output logic [2:0] o_pauseSrc,
    output logic       o_timeout,
    output logic       o_busy
);
    // state    | meaning
    // S_RUN    | idle, waiting for a request after boot
    // S_REQ    | start-pause asserted, waiting for both acks or timeout
    // S_PAUSED | formally paused while any request holds
    // S_RESUME | acks draining, then QUIET_CYC quiet cycles before RUN
    typedef enum logic [1:0] {S_RUN, S_REQ, S_PAUSED, S_RESUME} state_t;

    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_startPause;
    logic             r_isPaused;
    logic [2:0]       r_pauseSrc;
    logic             r_timeout;
    logic             r_busy;

    logic             w_anyReq;
    logic             w_bothAck;
    logic             w_eitherAck;
    logic [CNT_W-1:0] w_cntInc;

    assign w_anyReq    = i_pinPause | i_jtagPause | i_mapPause;
    assign w_bothAck   = i_coreNowPaused & i_mapNowPaused;
    assign w_eitherAck = i_coreNowPaused | i_mapNowPaused;
    assign w_cntInc    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_RUN;
            r_cnt        <= '0;
            r_startPause <= 1'b0;
            r_isPaused   <= 1'b0;
            r_pauseSrc   <= 3'b000;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // a timeout set later in this block overrides the clear
            if (i_clrTimeout) r_timeout <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (w_anyReq && i_isBooted) begin
                        r_state      <= S_REQ;
                        r_startPause <= 1'b1;
                        r_busy       <= 1'b1;
                        r_pauseSrc   <= {i_mapPause, i_jtagPause, i_pinPause};
                        r_cnt        <= '0;
                    end
                end
                S_REQ: begin
                    if (w_bothAck && w_anyReq) begin
                        r_state    <= S_PAUSED;
                        r_isPaused <= 1'b1;
                    end else if (!w_anyReq) begin
                        r_state      <= S_RESUME;
                        r_startPause <= 1'b0;
                        r_cnt        <= '0;
                    end else if (r_cnt == TO_LAST) begin
                        r_state      <= S_RESUME;
                        r_startPause <= 1'b0;
                        r_timeout    <= 1'b1;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= w_cntInc;
                    end
                end
                S_PAUSED: begin
                    // acks dropping here is a protocol error and is deliberately ignored
                    if (!w_anyReq) begin
                        r_state      <= S_RESUME;
                        r_startPause <= 1'b0;
                        r_isPaused   <= 1'b0;
                        r_cnt        <= '0;
                    end
                end
                S_RESUME: begin
                    if (w_eitherAck) begin
                        r_cnt <= '0;
                    end else if (r_cnt == QUIET_LAST) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cntInc;
                    end
                end
                default: begin
                    r_state      <= S_RUN;
                    r_startPause <= 1'b0;
                    r_isPaused   <= 1'b0;
                    r_busy       <= 1'b0;
                    r_cnt        <= '0;
                end
            endcase
        end
    end

    assign o_startPause = r_startPause;
    assign o_isPaused   = r_isPaused;
    assign o_pauseSrc   = r_pauseSrc;
    assign o_timeout    = r_timeout;
    assign o_busy       = r_busy;
endmodule

// File: tb/tb_pause_sequencer.sv
// Scoreboard bench for pause_sequencer: directed scenarios followed by random traffic,
// checked against a phase/age reference model.
module tb_pause_sequencer;
    localparam int TO = 8;
    localparam int QC = 4;

    logic       clk = 1'b0;
    logic       rst, pin, jtag, mapp, boot, cak, mak, clr;
    logic       o_startPause, o_isPaused, o_timeout, o_busy;
    logic [2:0] o_pauseSrc;

    pause_sequencer #(.TIMEOUT_CYC(TO), .QUIET_CYC(QC), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_pinPause(pin), .i_jtagPause(jtag), .i_mapPause(mapp),
        .i_isBooted(boot), .i_coreNowPaused(cak), .i_mapNowPaused(mak), .i_clrTimeout(clr),
        .o_startPause(o_startPause), .o_isPaused(o_isPaused), .o_pauseSrc(o_pauseSrc),
        .o_timeout(o_timeout), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef enum {IDLE, ASK, HELD, COOL} phase_t;
    phase_t     m_phase = IDLE;
    int         m_age, m_quiet;
    logic [2:0] m_src = 3'b000;
    logic       m_tmo = 1'b0;
    logic [6:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         done = 1'b0;

    // Reference model: what the outputs should be after each clock edge.
    always @(posedge clk) begin
        logic any, set_t;
        any   = pin | jtag | mapp;
        set_t = 1'b0;
        if (rst) begin
            m_phase = IDLE; m_src = 3'b000; m_tmo = 1'b0;
        end else begin
            case (m_phase)
                IDLE: if (any && boot) begin m_phase = ASK; m_age = 0; m_src = {mapp, jtag, pin}; end
                ASK: begin
                    m_age++;
                    if (cak && mak && any) m_phase = HELD;
                    else if (!any) begin m_phase = COOL; m_quiet = 0; end
                    else if (m_age == TO) begin m_phase = COOL; m_quiet = 0; set_t = 1'b1; end
                end
                HELD: if (!any) begin m_phase = COOL; m_quiet = 0; end
                COOL: begin
                    if (cak || mak) m_quiet = 0;
                    else begin
                        m_quiet++;
                        if (m_quiet == QC) m_phase = IDLE;
                    end
                end
            endcase
            if (set_t) m_tmo = 1'b1;
            else if (clr) m_tmo = 1'b0;
        end
        if (!done)
            exp_q.push_back({(m_phase == ASK || m_phase == HELD), (m_phase == HELD), m_src, m_tmo,
                             (m_phase != IDLE)});
    end

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    always @(negedge clk) begin
        logic [6:0] act, e;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {o_startPause, o_isPaused, o_pauseSrc, o_timeout, o_busy};
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL outputs t=%0t {start,paused,src,tmo,busy} actual=%b_%b_%b_%b_%b required=%b_%b_%b_%b_%b",
                         $time, act[6], act[5], act[4:2], act[1], act[0], e[6], e[5], e[4:2], e[1], e[0]);
            end
        end
    end

    task automatic check_val(input string label, input logic [6:0] act, input logic [6:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s t=%0t actual=%b required=%b", label, $time, act, exp_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic set_req(input logic p, input logic j, input logic m);
        pin = p; jtag = j; mapp = m;
    endtask

    initial begin
        rst = 1; pin = 0; jtag = 0; mapp = 0; boot = 0; cak = 0; mak = 0; clr = 0;
        cyc(3);
        check_val("reset state", {o_startPause, o_isPaused, o_pauseSrc, o_timeout, o_busy}, 7'b0);
        rst = 0; boot = 1; jtag = 1;
        cyc(1);                       // REQ entered
        cyc(3); cak = 1; mak = 1;
        cyc(5);
        jtag = 0;
        cyc(2); cak = 0; mak = 0;
        cyc(7);
        // ack timeout, then clear
        pin = 1;
        cyc(12);
        check_val("expired wait", {6'b0, o_timeout}, 7'b1);
        check_val("expired wait start", {6'b0, o_startPause}, 7'b0);
        pin = 0;
        cyc(6);
        clr = 1; cyc(1); clr = 0; cyc(2);
        check_val("timeout cleared", {6'b0, o_timeout}, 7'b0);
        // requests before boot are held off
        boot = 0; mapp = 1;
        cyc(20);
        boot = 1;
        cyc(3); cak = 1; mak = 1;
        cyc(3); mapp = 0;
        cyc(1); cak = 0; mak = 0;
        cyc(7);
        // acks on the last timeout cycle win
        pin = 1;
        cyc(1); cyc(TO - 1); cak = 1; mak = 1;
        cyc(3); pin = 0; cak = 0; mak = 0;
        cyc(8);
        // set and clear of timeout together: set wins
        jtag = 1;
        cyc(TO); clr = 1; cyc(1); clr = 0; jtag = 0;
        cyc(8);
        // reset while paused and while requesting
        jtag = 1; cyc(2); cak = 1; mak = 1; cyc(3);
        rst = 1; cyc(1); rst = 0; jtag = 0; cak = 0; mak = 0;
        cyc(2);
        mapp = 1; cyc(3); rst = 1; cyc(1); rst = 0;
        set_req(1, 1, 0); mapp = 0;
        cyc(4); set_req(0, 0, 0);
        cyc(8);
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) pin  = ~pin;
            if ($urandom_range(0, 11) == 0) jtag = ~jtag;
            if ($urandom_range(0, 13) == 0) mapp = ~mapp;
            boot = ($urandom_range(0, 19) != 0);
            clr  = ($urandom_range(0, 15) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            if (o_startPause) begin
                if ($urandom_range(0, 2) == 0) cak = 1;
                if ($urandom_range(0, 2) == 0) mak = 1;
                if ($urandom_range(0, 29) == 0) cak = 0;
            end else begin
                if ($urandom_range(0, 1) == 0) cak = 0;
                if ($urandom_range(0, 1) == 0) mak = 0;
            end
            cyc(1);
        end
        done = 1'b1;
        @(negedge clk); @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
